// File: rtl/id_ex_operand_stage_if.sv
// id_ex_operand_stage_if: decode, hazard, writeback and EX-operand signals of the ID/EX stage
interface id_ex_operand_stage_if;
    logic        id_valid;
    logic [4:0]  id_rs1_addr;
    logic [4:0]  id_rs2_addr;
    logic [4:0]  id_rd_addr;
    logic [31:0] id_rs1_data;
    logic [31:0] id_rs2_data;
    logic [3:0]  id_alu_ctrl;
    logic        id_reg_write;
    logic        stall;
    logic        flush;
    logic        exmem_reg_write;
    logic [4:0]  exmem_rd;
    logic [31:0] exmem_result;
    logic        memwb_reg_write;
    logic [4:0]  memwb_rd;
    logic [31:0] memwb_result;
    logic        ex_valid;
    logic [31:0] rs_1;
    logic [31:0] rs_2;
    logic [3:0]  alu_ctrl;
    logic [4:0]  ex_rd_addr;
    logic        ex_reg_write;
    logic [1:0]  fwd_a;
    logic [1:0]  fwd_b;

    modport master (
        output id_valid, id_rs1_addr, id_rs2_addr, id_rd_addr, id_rs1_data, id_rs2_data,
               id_alu_ctrl, id_reg_write, stall, flush,
               exmem_reg_write, exmem_rd, exmem_result, memwb_reg_write, memwb_rd, memwb_result,
        input  ex_valid, rs_1, rs_2, alu_ctrl, ex_rd_addr, ex_reg_write, fwd_a, fwd_b
    );

    modport slave (
        input  id_valid, id_rs1_addr, id_rs2_addr, id_rd_addr, id_rs1_data, id_rs2_data,
               id_alu_ctrl, id_reg_write, stall, flush,
               exmem_reg_write, exmem_rd, exmem_result, memwb_reg_write, memwb_rd, memwb_result,
        output ex_valid, rs_1, rs_2, alu_ctrl, ex_rd_addr, ex_reg_write, fwd_a, fwd_b
    );
endinterface

// File: rtl/id_ex_operand_stage.sv
// id_ex_operand_stage: ID/EX pipeline register with EX/MEM and MEM/WB operand forwarding
module id_ex_operand_stage (
    input logic                  clk,
    input logic                  rst,
    id_ex_operand_stage_if.slave bus
);
    logic        valid;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [3:0]  alu_ctrl_q;
    logic [4:0]  rd_addr;
    logic        reg_write;
    logic [1:0]  fwd_a;
    logic [1:0]  fwd_b;
    logic [31:0] rs_1;
    logic [31:0] rs_2;

    // forward select: EX/MEM beats MEM/WB, x0 and bubbles never forwarded
    always_comb begin
        fwd_a = !valid || rs1_addr == 5'd0 ? 2'b00 :
                bus.exmem_reg_write && bus.exmem_rd == rs1_addr ? 2'b10 :
                bus.memwb_reg_write && bus.memwb_rd == rs1_addr ? 2'b01 : 2'b00;
        fwd_b = !valid || rs2_addr == 5'd0 ? 2'b00 :
                bus.exmem_reg_write && bus.exmem_rd == rs2_addr ? 2'b10 :
                bus.memwb_reg_write && bus.memwb_rd == rs2_addr ? 2'b01 : 2'b00;
        rs_1  = fwd_a == 2'b10 ? bus.exmem_result : fwd_a == 2'b01 ? bus.memwb_result : op_a;
        rs_2  = fwd_b == 2'b10 ? bus.exmem_result : fwd_b == 2'b01 ? bus.memwb_result : op_b;
    end

    // slot update: reset/flush clear, stall holds but refreshes operands with forwarded values
    always_ff @(posedge clk) begin
        if (rst || bus.flush) begin
            valid      <= 1'b0;
            rs1_addr   <= 5'd0;
            rs2_addr   <= 5'd0;
            op_a       <= 32'd0;
            op_b       <= 32'd0;
            alu_ctrl_q <= 4'd0;
            rd_addr    <= 5'd0;
            reg_write  <= 1'b0;
        end else if (bus.stall) begin
            op_a       <= rs_1;
            op_b       <= rs_2;
        end else begin
            valid      <= bus.id_valid;
            rs1_addr   <= bus.id_rs1_addr;
            rs2_addr   <= bus.id_rs2_addr;
            op_a       <= bus.id_rs1_data;
            op_b       <= bus.id_rs2_data;
            alu_ctrl_q <= bus.id_alu_ctrl;
            rd_addr    <= bus.id_rd_addr;
            reg_write  <= bus.id_reg_write;
        end
    end

    assign bus.ex_valid     = valid;
    assign bus.alu_ctrl     = alu_ctrl_q;
    assign bus.ex_rd_addr   = rd_addr;
    assign bus.ex_reg_write = reg_write;
    assign bus.fwd_a        = fwd_a;
    assign bus.fwd_b        = fwd_b;
    assign bus.rs_1         = rs_1;
    assign bus.rs_2         = rs_2;
endmodule

// File: tb/tb_id_ex_operand_stage.sv
// tb_id_ex_operand_stage: directed scenarios plus random traffic against a slot-level reference model
module tb_id_ex_operand_stage;
    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    id_ex_operand_stage_if bus ();

    id_ex_operand_stage dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          v;
        bit   [4:0]  a1;
        bit   [4:0]  a2;
        bit   [31:0] op1;
        bit   [31:0] op2;
        bit   [3:0]  ctrl;
        bit   [4:0]  rd;
        bit          rw;
    } slot_t;

    slot_t m;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic idle();
        rst = 1'b0;
        bus.id_valid = 0; bus.id_rs1_addr = 0; bus.id_rs2_addr = 0; bus.id_rd_addr = 0;
        bus.id_rs1_data = 0; bus.id_rs2_data = 0; bus.id_alu_ctrl = 0; bus.id_reg_write = 0;
        bus.stall = 0; bus.flush = 0;
        bus.exmem_reg_write = 0; bus.exmem_rd = 0; bus.exmem_result = 0;
        bus.memwb_reg_write = 0; bus.memwb_rd = 0; bus.memwb_result = 0;
    endtask

    task automatic issue(input bit [4:0] a1, input bit [31:0] d1, input bit [4:0] a2,
                         input bit [31:0] d2, input bit [3:0] ctrl, input bit [4:0] rd);
        bus.id_valid = 1; bus.id_rs1_addr = a1; bus.id_rs1_data = d1;
        bus.id_rs2_addr = a2; bus.id_rs2_data = d2; bus.id_alu_ctrl = ctrl;
        bus.id_rd_addr = rd; bus.id_reg_write = 1;
    endtask

    // Which source a register read in the live slot should come from: 2 EX/MEM, 1 MEM/WB, 0 stored
    function automatic int source(input bit [4:0] a);
        if (!m.v || a == 0) return 0;
        if (bus.exmem_reg_write && bus.exmem_rd == a) return 2;
        if (bus.memwb_reg_write && bus.memwb_rd == a) return 1;
        return 0;
    endfunction

    function automatic bit [31:0] value(input int src, input bit [31:0] stored);
        return src == 2 ? bus.exmem_result : src == 1 ? bus.memwb_result : stored;
    endfunction

    task automatic step();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic check_zero(input string tag);
        check({tag, ".valid"}, bus.ex_valid, 0);
        check({tag, ".alu"}, bus.alu_ctrl, 0);
        check({tag, ".rd"}, bus.ex_rd_addr, 0);
        check({tag, ".rw"}, bus.ex_reg_write, 0);
        check({tag, ".rs1"}, bus.rs_1, 0);
        check({tag, ".rs2"}, bus.rs_2, 0);
        check({tag, ".fa"}, bus.fwd_a, 0);
        check({tag, ".fb"}, bus.fwd_b, 0);
    endtask

    initial begin
        int s1, s2;
        bit [31:0] e1, e2;
        idle();
        rst = 1; bus.stall = 1; bus.flush = 1;
        step();
        step();
        check_zero("reset");

        idle();
        issue(5, 32'h10, 6, 32'h20, 4'b1000, 3);
        step();
        check("load.valid", bus.ex_valid, 1);
        check("load.rs1", bus.rs_1, 32'h10);
        check("load.rs2", bus.rs_2, 32'h20);
        check("load.fa", bus.fwd_a, 0);
        check("load.fb", bus.fwd_b, 0);
        check("load.alu", bus.alu_ctrl, 4'b1000);
        check("load.rd", bus.ex_rd_addr, 3);
        check("load.rw", bus.ex_reg_write, 1);

        idle();
        bus.stall = 1;
        bus.exmem_reg_write = 1; bus.exmem_rd = 5; bus.exmem_result = 32'hAAAA;
        bus.memwb_reg_write = 1; bus.memwb_rd = 5; bus.memwb_result = 32'hBBBB;
        #1;
        check("both.rs1", bus.rs_1, 32'hAAAA);
        check("both.fa", bus.fwd_a, 2);
        check("both.rs2", bus.rs_2, 32'h20);
        bus.exmem_reg_write = 0;
        #1;
        check("memwb.rs1", bus.rs_1, 32'hBBBB);
        check("memwb.fa", bus.fwd_a, 1);

        idle();
        issue(7, 32'h1, 0, 32'h1234, 4'b1001, 4);
        step();
        idle();
        bus.stall = 1;
        bus.exmem_reg_write = 1; bus.exmem_rd = 0; bus.exmem_result = 32'hFFFF;
        #1;
        check("x0.rs2", bus.rs_2, 32'h1234);
        check("x0.fb", bus.fwd_b, 0);

        bus.exmem_rd = 7; bus.exmem_result = 32'h55;
        #1;
        check("stall1.rs1", bus.rs_1, 32'h55);
        check("stall1.fa", bus.fwd_a, 2);
        step();
        bus.exmem_reg_write = 0; bus.exmem_result = 0;
        #1;
        check("stall2.rs1", bus.rs_1, 32'h55);
        check("stall2.fa", bus.fwd_a, 0);
        check("stall2.alu", bus.alu_ctrl, 4'b1001);
        check("stall2.valid", bus.ex_valid, 1);

        bus.flush = 1;
        issue(7, 32'h9, 7, 32'h9, 4'b0011, 5);
        step();
        idle();
        bus.stall = 1;
        bus.exmem_reg_write = 1; bus.exmem_rd = 0; bus.exmem_result = 32'h77;
        #1;
        check_zero("flush");

        idle();
        issue(8, 32'h8, 9, 32'h9, 4'b0101, 6);
        step();
        idle();
        rst = 1; bus.stall = 1;
        step();
        check_zero("rst_stall");
        idle();
        issue(9, 32'h99, 10, 32'hA0, 4'b0010, 11);
        step();
        check("post_rst.valid", bus.ex_valid, 1);
        check("post_rst.rs1", bus.rs_1, 32'h99);
        check("post_rst.rs2", bus.rs_2, 32'hA0);
        check("post_rst.rd", bus.ex_rd_addr, 11);

        idle();
        rst = 1;
        step();
        m = '{default: 0};
        for (int i = 0; i < 3000; i++) begin
            rst = $urandom_range(49, 0) == 0;
            bus.flush = $urandom_range(7, 0) == 0;
            bus.stall = $urandom_range(3, 0) == 0;
            bus.id_valid = $urandom_range(3, 0) != 0;
            bus.id_rs1_addr = 5'($urandom_range(7, 0));
            bus.id_rs2_addr = 5'($urandom_range(7, 0));
            bus.id_rd_addr = 5'($urandom);
            bus.id_rs1_data = $urandom;
            bus.id_rs2_data = $urandom;
            bus.id_alu_ctrl = 4'($urandom);
            bus.id_reg_write = 1'($urandom);
            bus.exmem_reg_write = 1'($urandom);
            bus.exmem_rd = 5'($urandom_range(7, 0));
            bus.exmem_result = $urandom;
            bus.memwb_reg_write = 1'($urandom);
            bus.memwb_rd = 5'($urandom_range(7, 0));
            bus.memwb_result = $urandom;
            #1;
            s1 = source(m.a1);
            s2 = source(m.a2);
            e1 = value(s1, m.op1);
            e2 = value(s2, m.op2);
            check("rnd.valid", bus.ex_valid, m.v);
            check("rnd.alu", bus.alu_ctrl, m.ctrl);
            check("rnd.rd", bus.ex_rd_addr, m.rd);
            check("rnd.rw", bus.ex_reg_write, m.rw);
            check("rnd.fa", bus.fwd_a, s1);
            check("rnd.fb", bus.fwd_b, s2);
            check("rnd.rs1", bus.rs_1, e1);
            check("rnd.rs2", bus.rs_2, e2);
            @(posedge clk);
            if (rst || bus.flush) m = '{default: 0};
            else if (bus.stall) begin
                m.op1 = e1;
                m.op2 = e2;
            end else
                m = '{bus.id_valid, bus.id_rs1_addr, bus.id_rs2_addr, bus.id_rs1_data,
                      bus.id_rs2_data, bus.id_alu_ctrl, bus.id_rd_addr, bus.id_reg_write};
            @(negedge clk);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/id_ex_operand_stage.md
ID_EX_OPERAND_STAGE -- requirements
Module: id_ex_operand_stage

Interface
REQ-001 SHALL have one clock; reset is synchronous and active-high.
REQ-002 clk  in  1  rising-edge clock for all state.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 id_valid  in  1  decode slot holds a real instruction.
REQ-005 id_rs1_addr, id_rs2_addr, id_rd_addr  in  5 each  register indices from decode.
REQ-006 id_rs1_data, id_rs2_data  in  32 each  register-file read data.
REQ-007 id_alu_ctrl  in  4  ALU/compare opcode (4'b1000 SLT, 4'b1001 SLTU, others per ALU map).
REQ-008 id_reg_write  in  1  instruction writes rd.
REQ-009 stall  in  1  hold the EX slot this cycle.
REQ-010 flush  in  1  kill the EX slot this cycle.
REQ-011 exmem_reg_write, exmem_rd[4:0], exmem_result[31:0]  in  EX/MEM writeback source.
REQ-012 memwb_reg_write, memwb_rd[4:0], memwb_result[31:0]  in  MEM/WB writeback source.
REQ-013 ex_valid  out  1  EX slot holds a live instruction.
REQ-014 rs_1, rs_2  out  32 each  forwarded operands to the ALU/compare unit.
REQ-015 alu_ctrl  out  4  registered opcode to the ALU/compare unit.
REQ-016 ex_rd_addr  out  5; ex_reg_write  out  1  registered destination info.
REQ-017 fwd_a, fwd_b  out  2 each  forward select: 00 regfile, 01 MEM/WB, 10 EX/MEM.

Function
REQ-018 Stored state: valid, rs1_addr, rs2_addr, op_a, op_b, alu_ctrl, rd_addr, reg_write.
REQ-019 Per edge, priority rst > flush > stall > load.
REQ-020 flush=1: valid, alu_ctrl, rd_addr, reg_write load 0; op_a/op_b/rs addrs load 0; regardless of stall.
REQ-021 Load (no rst/flush/stall): all fields capture id_* inputs; valid captures id_valid.
REQ-022 stall=1 (no flush): valid, addrs, alu_ctrl, rd_addr, reg_write hold; op_a/op_b load current rs_1/rs_2 (forwarded refresh), so a held operand survives its producer retiring.
REQ-023 fwd_a = 10 when exmem_reg_write, exmem_rd!=0, exmem_rd==rs1_addr; else 01 when memwb_reg_write, memwb_rd!=0, memwb_rd==rs1_addr; else 00; fwd_b identical on rs2_addr.
REQ-024 Both EX/MEM and MEM/WB match: EX/MEM wins.
REQ-025 Register x0 never forwarded; rs_1/rs_2 = stored op for index 0.
REQ-026 ex_valid=0: fwd_a=fwd_b=00, rs_1=op_a, rs_2=op_b (no forwarding into bubbles).
REQ-027 rs_1/rs_2/fwd_* combinational from stored state and current exmem/memwb inputs; all other outputs direct register outputs.
REQ-028 Latency: id_* captured at edge N appear on outputs after edge N, one cycle.
REQ-029 id_valid=0 load: valid=0 but fields still captured; downstream qualifies by ex_valid.
REQ-030 No combinational path from stall/flush to any output.

Reset
REQ-031 rst=1 at edge: all stored fields 0; ex_valid=0, alu_ctrl=4'b0000, ex_rd_addr=0, ex_reg_write=0, rs_1=rs_2=0, fwd_a=fwd_b=00 next cycle.
REQ-032 rst overrides stall and flush in the same cycle; first load occurs on the first edge with rst=0.

Verification
REQ-033 Load id_valid=1, rs1=5 data 0x10, rs2=6 data 0x20, alu_ctrl=1000, no writeback -> next cycle ex_valid=1, rs_1=0x10, rs_2=0x20, fwd=00/00.
REQ-034 Stored rs1=5; exmem_rd=5 result 0xAAAA, memwb_rd=5 result 0xBBBB, both reg_write -> rs_1=0xAAAA, fwd_a=10.
REQ-035 Stored rs2=0; exmem_rd=0 reg_write=1 result 0xFFFF -> rs_2=op_b, fwd_b=00.
REQ-036 Stall 2 cycles with exmem_rd=7 (=rs1) result 0x55 in cycle 1 only -> cycle 2 rs_1=0x55 via refreshed op_a, fwd_a=00; alu_ctrl unchanged.
REQ-037 flush and stall together with valid slot -> next cycle ex_valid=0, alu_ctrl=0000, ex_reg_write=0.
REQ-038 rst mid-stream with stall=1 -> next cycle all outputs 0; following load with id_valid=1 captured normally.
